rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between N_REQ writeback requesters, e.g. req 0 = ALU/jump writeback and req 1 = load writeback.
- Arbitration is round-robin with a valid/ready handshake.
- Granted writes pass through one registered issue stage that drives rd, rd_din and write_enable of the register file.
- The stage contents also drive a pending-write hazard/bypass check on the two read ports and a saturating stall counter for the testbench.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/rf_write_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register-file package: data width, register addressing and the
// hard-wired zero register. Shared with the register file and datapath.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // x0 is hard-wired to zero; any write addressed to it is discarded.
  function automatic logic is_writable(input reg_addr_t rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational priority search starting at ptr,
// plus the ptr register that moves one past the winner on a transfer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  input  logic                 advance_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  // First requester at or after ptr (wrapping) wins; at most one grant.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDX_W'((int'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

  // Next pointer: one past the winner on a transfer, else hold.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin grant among writeback
// requesters, one registered issue stage driving the write port, a
// pending-write hazard/bypass check and a saturating stall counter.
module rf_write_arbiter #(
  parameter int N_REQ   = 2,
  parameter int XLEN    = rf_pkg::XLEN,
  parameter int STALL_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*5-1:0]    req_rd,
  input  logic [N_REQ*XLEN-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rf_we,
  output logic [4:0]            rf_rd,
  output logic [XLEN-1:0]       rf_din,
  input  logic [4:0]            rs1_q,
  input  logic [4:0]            rs2_q,
  output logic                  rs1_pend,
  output logic                  rs2_pend,
  output logic [XLEN-1:0]       byp_data,
  output logic [STALL_W-1:0]    stall_cnt
);

  import rf_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);

  // Handshake: a write moves from requester i into the issue stage on a
  // rising edge where req_valid[i] & req_ready[i]. req_ready is a one-hot
  // function of req_valid and the pointer only (never of itself) and is
  // forced to zero while reset is high. Once valid rises, the requester
  // keeps valid, rd and data stable until the transfer edge.

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             xfer;

  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;

  logic                we_q,  we_d;
  logic [4:0]          rd_q,  rd_d;
  logic [XLEN-1:0]     din_q, din_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                stall_any;

  assign arb_req = reset ? '0 : req_valid;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (arb_req),
    .advance_i   (xfer),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  // Route the winning requester's rd/data toward the issue stage.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Issue-stage next state: load on transfer, x0 writes never enable.
  always_comb begin
    we_d  = 1'b0;
    rd_d  = rd_q;
    din_d = din_q;
    if (xfer) begin
      rd_d  = sel_rd;
      din_d = sel_data;
      we_d  = is_writable(sel_rd);
    end
  end

  // Stall counter next state: counts cycles with a waiting request, saturating.
  always_comb begin
    stall_any = ~reset & (|(req_valid & ~grant));
    stall_d   = stall_q;
    if (stall_any && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // Issue-stage and stall-counter registers; reset drops an uncommitted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      rd_q    <= REG_ZERO;
      din_q   <= '0;
      stall_q <= '0;
    end else begin
      we_q    <= we_d;
      rd_q    <= rd_d;
      din_q   <= din_d;
      stall_q <= stall_d;
    end
  end

  assign rf_we     = we_q;
  assign rf_rd     = rd_q;
  assign rf_din    = din_q;
  assign byp_data  = din_q;
  assign stall_cnt = stall_q;

  assign rs1_pend = we_q & (rd_q == rs1_q) & (rs1_q != REG_ZERO);
  assign rs2_pend = we_q & (rd_q == rs2_q) & (rs2_q != REG_ZERO);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then randomized traffic,
// checked against a behavioural model with a write scoreboard.
module tb_rf_write_arbiter;

  localparam int N    = 2;
  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [N-1:0]      v;
  logic [4:0]        rdv [N];
  logic [XLEN-1:0]   dv  [N];
  logic [N*5-1:0]    req_rd;
  logic [N*XLEN-1:0] req_data;
  logic [4:0]        rs1, rs2;

  logic [N-1:0]    ready, ready3;
  logic            we, we3, p1, p2, p13, p23;
  logic [4:0]      rd, rd3;
  logic [XLEN-1:0] din, din3, byp, byp3;
  logic [7:0]      stall;
  logic [2:0]      stall3;

  always_comb begin
    req_rd   = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_rd[i*5 +: 5]      = rdv[i];
      req_data[i*XLEN +: XLEN] = dv[i];
    end
  end

  rf_write_arbiter #(.N_REQ(N), .XLEN(XLEN), .STALL_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(v), .req_rd(req_rd), .req_data(req_data),
    .req_ready(ready), .rf_we(we), .rf_rd(rd), .rf_din(din),
    .rs1_q(rs1), .rs2_q(rs2), .rs1_pend(p1), .rs2_pend(p2),
    .byp_data(byp), .stall_cnt(stall)
  );

  rf_write_arbiter #(.N_REQ(N), .XLEN(XLEN), .STALL_W(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v), .req_rd(req_rd), .req_data(req_data),
    .req_ready(ready3), .rf_we(we3), .rf_rd(rd3), .rf_din(din3),
    .rs1_q(rs1), .rs2_q(rs2), .rs1_pend(p13), .rs2_pend(p23),
    .byp_data(byp3), .stall_cnt(stall3)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [36:0] exp_q [$];

  // behavioural model
  int              m_ptr = 0;
  logic            m_we  = 1'b0;
  logic [4:0]      m_rd  = '0;
  logic [XLEN-1:0] m_din = '0;
  int              m_stall  = 0;
  int              m_stall3 = 0;

  logic [XLEN-1:0] rf_mem  [32];
  logic [XLEN-1:0] ref_mem [32];

  logic [N-1:0] acc;
  logic [N-1:0] pv, pacc;
  logic         prst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] vv, input int p);
    for (int k = 0; k < N; k++) begin
      if (vv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Register file fed by the DUT write port (reset suppresses the commit).
  always @(posedge clk) begin
    if (!reset && we && rd != 5'd0) rf_mem[rd] <= din;
  end

  // Accepted requests, sampled away from the edge for the driver.
  always @(negedge clk) acc = v & ready & {N{~reset}};

  // Per-cycle checker and model update.
  always @(negedge clk) begin : model_chk
    int g;
    logic [N-1:0] er;
    logic any;
    if (chk_en) begin
      g  = reset ? -1 : pick(v, m_ptr);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", 64'(ready), 64'(er));
      check("req_ready_s3", 64'(ready3), 64'(er));
      check("rf_we", 64'(we), 64'(m_we));
      check("rf_rd", 64'(rd), 64'(m_rd));
      check("rf_din", 64'(din), 64'(m_din));
      check("byp_data", 64'(byp), 64'(m_din));
      check("rs1_pend", 64'(p1), 64'(m_we && m_rd == rs1 && rs1 != 0));
      check("rs2_pend", 64'(p2), 64'(m_we && m_rd == rs2 && rs2 != 0));
      check("stall_cnt", 64'(stall), 64'(m_stall));
      check("stall_cnt_s3", 64'(stall3), 64'(m_stall3));
      check("issue_s3", {p13, p23, we3, rd3, din3}, {p1 === 1'b1, p2 === 1'b1, m_we, m_rd, m_din});
      if (!reset && !prst) begin
        for (int i = 0; i < N; i++) begin
          if (pv[i] && !pacc[i] && !v[i]) begin
            errors++;
            $display("FAIL handshake: requester %0d dropped valid before acceptance", i);
          end
        end
      end
      // pending write commits at the coming edge unless reset is high
      if (!reset && m_we) ref_mem[m_rd] = m_din;
      if (reset) begin
        m_ptr = 0; m_we = 1'b0; m_rd = '0; m_din = '0; m_stall = 0; m_stall3 = 0;
      end else begin
        any = 1'b0;
        for (int i = 0; i < N; i++) if (v[i] && i != g) any = 1'b1;
        if (any && m_stall  < 255) m_stall++;
        if (any && m_stall3 < 7)   m_stall3++;
        if (g >= 0) begin
          m_ptr = (g + 1) % N;
          m_rd  = rdv[g];
          m_din = dv[g];
          m_we  = (rdv[g] != 5'd0);
          if (m_we) exp_q.push_back({m_rd, m_din});
        end else begin
          m_we = 1'b0;
        end
      end
      pv   = v;
      pacc = er;
      prst = reset;
    end
  end

  // Monitor: every enabled write on the port must match the oldest expected one.
  always @(negedge clk) begin : wr_mon
    logic [36:0] e;
    if (chk_en && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL write_unexpected: rd=%0d din=%0h with empty queue", rd, din);
      end else begin
        e = exp_q.pop_front();
        check("write", 64'({rd, din}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic val, input logic [4:0] r, input logic [XLEN-1:0] d);
    v[i]   = val;
    rdv[i] = r;
    dv[i]  = d;
  endtask

  // Release each requester only once it has been accepted.
  task automatic drain();
    int n;
    n = 0;
    while (v != '0 && n < 8) begin
      cycle();
      v = v & ~acc;
      n++;
    end
    if (v != '0) begin
      errors++; checks++;
      $display("FAIL drain_timeout: valid=%b still pending", v);
      v = '0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [XLEN-1:0] d7, old9;
    logic was_rst;
    v = '0; rs1 = '0; rs2 = '0; prst = 1'b1; pv = '0; pacc = '0; acc = '0;
    for (int i = 0; i < N; i++) begin rdv[i] = '0; dv[i] = '0; end
    for (int i = 0; i < 32; i++) begin rf_mem[i] = '0; ref_mem[i] = '0; end

    @(posedge clk); #1;
    chk_en = 1'b1;
    cycle();
    reset = 1'b0;

    // 1: single request, 1-cycle latency, commit one edge later
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk); check("t1_ready", 64'(ready), 64'b01);
    cycle(); v[0] = 1'b0;
    @(negedge clk);
    check("t1_we", 64'(we), 64'd1);
    check("t1_rd", 64'(rd), 64'd5);
    check("t1_din", 64'(din), 64'hDEAD_BEEF);
    cycle(); check("t1_rf5", 64'(rf_mem[5]), 64'hDEAD_BEEF);

    // 2: both valid, alternating grants from ptr=0
    reset = 1'b1; cycle(); reset = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'hAAAA_AAAA);
    set_req(1, 1'b1, 5'd2, 32'hBBBB_BBBB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("t2_grant", 64'(ready), (i % 2) ? 64'b10 : 64'b01);
      cycle();
    end
    check("t2_stall", 64'(stall), 64'd4);
    drain();

    // 3: x0 write accepted but never enabled
    set_req(1, 1'b1, 5'd0, 32'h0000_1234);
    @(negedge clk); check("t3_ready", 64'(ready), 64'b10);
    cycle(); v[1] = 1'b0; rs1 = 5'd0;
    @(negedge clk);
    check("t3_we", 64'(we), 64'd0);
    check("t3_rs1_pend_x0", 64'(p1), 64'd0);
    check("t3_rf0", 64'(rf_mem[0]), 64'd0);

    // 4: hazard and bypass on the pending write
    d7 = $urandom;
    cycle();
    set_req(0, 1'b1, 5'd7, d7);
    cycle(); v[0] = 1'b0; rs1 = 5'd7; rs2 = 5'd8;
    @(negedge clk);
    check("t4_rs1_pend", 64'(p1), 64'd1);
    check("t4_rs2_pend", 64'(p2), 64'd0);
    check("t4_byp", 64'(byp), 64'(d7));

    // 5: reset with a latched write drops it
    cycle();
    old9 = rf_mem[9];
    set_req(0, 1'b1, 5'd9, 32'h9999_0009);
    cycle(); v[0] = 1'b0; reset = 1'b1;
    set_req(1, 1'b1, 5'd3, 32'h3333_3333);
    @(negedge clk); check("t5_ready_in_reset", 64'(ready), 64'd0);
    cycle(); reset = 1'b0; v[1] = 1'b0;
    check("t5_we", 64'(we), 64'd0);
    check("t5_stall", 64'(stall), 64'd0);
    cycle(); check("t5_rf9", 64'(rf_mem[9]), 64'(old9));

    // 6: sustained contention saturates the 3-bit counter
    set_req(0, 1'b1, 5'd10, 32'h1010_1010);
    set_req(1, 1'b1, 5'd11, 32'h1111_1111);
    repeat (20) cycle();
    check("t6_stall3_sat", 64'(stall3), 64'd7);
    check("t6_stall8", 64'(stall), 64'd20);
    drain();

    // randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      cycle();
      was_rst = reset;
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (was_rst || acc[i] || !v[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, 1'b1, 5'($urandom_range(0, 7)), $urandom);
          else
            v[i] = 1'b0;
        end
      end
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
    end
    cycle();
    reset = 1'b0;
    cycle();
    drain();
    repeat (3) cycle();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 1; i < 32; i++) check("rf_final", 64'(rf_mem[i]), 64'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
